// File: rtl/kcpu_pkg.sv
// kcpu_pkg: shared types for the kcpu datapath.
//   sb_sel_t  - special-bus source select
//   bi_sel_t  - ALU B-input source select
//   alu_op_t  - ALU operation
//   ctl_t     - per-cycle control word from the sequencer
//   FLAG_*    - bit positions inside the {N,V,Z,C} flags vector
package kcpu_pkg;

  localparam int unsigned IDX_W   = 3;  // sized for up to 8 index registers
  localparam int unsigned MAX_IDX = 8;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 3;

  typedef enum logic [2:0] {
    SB_ZERO = 3'd0,
    SB_AC   = 3'd1,
    SB_IDX  = 3'd2,
    SB_ADD  = 3'd3,
    SB_DL   = 3'd4
  } sb_sel_t;

  typedef enum logic [1:0] {
    BI_HOLD = 2'd0,
    BI_DL   = 2'd1,
    BI_DL_N = 2'd2,
    BI_ADL  = 2'd3
  } bi_sel_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_AND = 3'd1,
    ALU_OR  = 3'd2,
    ALU_EOR = 3'd3,
    ALU_SR  = 3'd4
  } alu_op_t;

  typedef struct packed {
    sb_sel_t          sb_sel;
    logic [IDX_W-1:0] idx;
    logic             ld_ac;
    logic             ld_idx;
    logic             ld_ai;
    bi_sel_t          bi_sel;
    alu_op_t          alu_op;
    logic             cin_sel;
    logic             cin_val;
    logic             ld_add;
    logic             upd_flags;
    logic             ld_flags_db;
    logic             ld_abl;
    logic             adl_sel;
    logic             ld_abh;
    logic             adh_sel;
    logic             ab_inc;
    logic             ld_ir;
    logic             wr;
  } ctl_t;

endpackage

// File: rtl/kcpu_alu.sv
// kcpu_alu: purely combinational ALU.
//   op     - operation select
//   ai, bi - operands
//   cin    - carry / shift-in bit
//   c_flag - current C flag, passed through as carry-out for logic ops
//   r      - result
//   co     - carry out (ADD carry, SR shifted-out bit, else c_flag)
//   v      - signed overflow (ADD only, else 0)
module kcpu_alu
  import kcpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] ai,
  input  logic [DATA_W-1:0] bi,
  input  logic              cin,
  input  logic              c_flag,
  output logic [DATA_W-1:0] r,
  output logic              co,
  output logic              v
);

  logic [DATA_W:0] sum;

  assign sum = {1'b0, ai} + {1'b0, bi} + (DATA_W+1)'(cin);

  // Operation decode
  always_comb begin
    r  = '0;
    co = c_flag;
    v  = 1'b0;
    case (op)
      ALU_ADD: begin
        r  = sum[DATA_W-1:0];
        co = sum[DATA_W];
        // Same-sign operands producing an opposite-sign result
        v  = (ai[DATA_W-1] == bi[DATA_W-1]) && (sum[DATA_W-1] != ai[DATA_W-1]);
      end
      ALU_AND: r = ai & bi;
      ALU_OR:  r = ai | bi;
      ALU_EOR: r = ai ^ bi;
      ALU_SR: begin
        r  = {cin, ai[DATA_W-1:1]};
        co = ai[0];
      end
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/kcpu_datapath.sv
// kcpu_datapath: single-clock 6502-style datapath driven by a control word.
//   ph0   - clock, state updates on rising edge
//   reset - asynchronous active-high reset
//   rdy   - memory ready; low stalls read cycles
//   ctl   - control word for the current cycle
//   d_in  - memory read data
//   d_out - write data (accumulator)
//   d_oe  - write strobe for the cycle presented on a
//   a     - address register
//   ir    - instruction register
//   flags - {N,V,Z,C}
module kcpu_datapath
  import kcpu_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned NUM_IDX   = 2,
  parameter logic [15:0] RESET_VEC = 16'hFFFC
) (
  input  logic              ph0,
  input  logic              reset,
  input  logic              rdy,
  input  ctl_t              ctl,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  output logic              d_oe,
  output logic [ADDR_W-1:0] a,
  output logic [DATA_W-1:0] ir,
  output logic [3:0]        flags
);

  localparam int unsigned AH_W = ADDR_W - DATA_W;

  logic [DATA_W-1:0] ac;
  logic [DATA_W-1:0] idx_r [NUM_IDX];
  logic [DATA_W-1:0] ai;
  logic [DATA_W-1:0] bi;
  logic [DATA_W-1:0] add_r;
  logic [DATA_W-1:0] dl;

  logic              en;
  logic [DATA_W-1:0] sb;
  logic [DATA_W-1:0] bi_next;
  logic [ADDR_W-1:0] a_next;
  logic              cin;
  logic [DATA_W-1:0] alu_r;
  logic              alu_co;
  logic              alu_v;

  // Write cycles complete regardless of memory ready
  assign en    = rdy | ctl.wr;
  assign d_out = ac;
  assign cin   = ctl.cin_sel ? flags[FLAG_C] : ctl.cin_val;

  // Special bus source; unimplemented index registers read as zero
  always_comb begin
    sb = '0;
    case (ctl.sb_sel)
      SB_AC:  sb = ac;
      SB_ADD: sb = add_r;
      SB_DL:  sb = dl;
      SB_IDX: begin
        for (int i = 0; i < int'(NUM_IDX); i++) begin
          if (ctl.idx == IDX_W'(i)) sb = idx_r[i];
        end
      end
      default: sb = '0;
    endcase
  end

  // B-input source
  always_comb begin
    bi_next = bi;
    case (ctl.bi_sel)
      BI_DL:   bi_next = dl;
      BI_DL_N: bi_next = ~dl;
      BI_ADL:  bi_next = a[DATA_W-1:0];
      default: bi_next = bi;
    endcase
  end

  // Address update: a half-load suppresses the increment for the whole register
  always_comb begin
    a_next = a;
    if (ctl.ab_inc && !ctl.ld_abl && !ctl.ld_abh) a_next = a + ADDR_W'(1);
    if (ctl.ld_abl) a_next[DATA_W-1:0] = ctl.adl_sel ? dl : add_r;
    if (ctl.ld_abh) a_next[ADDR_W-1:DATA_W] = ctl.adh_sel ? AH_W'(dl) : AH_W'(sb);
  end

  kcpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (ctl.alu_op),
    .ai     (ai),
    .bi     (bi),
    .cin    (cin),
    .c_flag (flags[FLAG_C]),
    .r      (alu_r),
    .co     (alu_co),
    .v      (alu_v)
  );

  // Datapath registers
  always_ff @(posedge ph0 or posedge reset) begin
    if (reset) begin
      ac    <= '0;
      ai    <= '0;
      bi    <= '0;
      add_r <= '0;
      dl    <= '0;
      ir    <= '0;
      flags <= '0;
      d_oe  <= 1'b0;
      a     <= ADDR_W'(RESET_VEC);
      for (int i = 0; i < int'(NUM_IDX); i++) idx_r[i] <= '0;
    end else if (en) begin
      dl   <= d_in;
      d_oe <= ctl.wr;
      bi   <= bi_next;
      a    <= a_next;
      if (ctl.ld_ac)  ac    <= sb;
      if (ctl.ld_ai)  ai    <= sb;
      if (ctl.ld_add) add_r <= alu_r;
      if (ctl.ld_ir)  ir    <= d_in;
      for (int i = 0; i < int'(NUM_IDX); i++) begin
        if (ctl.ld_idx && ctl.idx == IDX_W'(i)) idx_r[i] <= sb;
      end
      if (ctl.ld_flags_db) begin
        flags <= dl[3:0];
      end else if (ctl.ld_add && ctl.upd_flags) begin
        flags[FLAG_N] <= alu_r[DATA_W-1];
        flags[FLAG_Z] <= (alu_r == '0);
        if (ctl.alu_op == ALU_ADD || ctl.alu_op == ALU_SR) flags[FLAG_C] <= alu_co;
        if (ctl.alu_op == ALU_ADD) flags[FLAG_V] <= alu_v;
      end
    end
  end

  // Loading AC during a write would put stale data on d_out for the strobe
  a_no_ld_ac_on_wr : assert property (@(posedge ph0) disable iff (reset) !(ctl.wr && ctl.ld_ac));

endmodule

// File: tb/tb_kcpu_datapath.sv
// tb_kcpu_datapath: directed scenarios plus randomized control words,
// checked against an integer-arithmetic reference model.
module tb_kcpu_datapath;
  import kcpu_pkg::*;

  localparam int unsigned NIDX = 4;

  logic        ph0;
  logic        reset;
  logic        rdy;
  ctl_t        ctl;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        d_oe;
  logic [15:0] a;
  logic [7:0]  ir;
  logic [3:0]  flags;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (plain integers)
  int m_ac, m_ai, m_bi, m_add, m_dl, m_ir, m_a, m_oe;
  int m_n, m_v, m_z, m_c;
  int m_idx [NIDX];

  kcpu_datapath #(.DATA_W(8), .ADDR_W(16), .NUM_IDX(NIDX), .RESET_VEC(16'hFFFC)) dut (
    .ph0   (ph0),
    .reset (reset),
    .rdy   (rdy),
    .ctl   (ctl),
    .d_in  (d_in),
    .d_out (d_out),
    .d_oe  (d_oe),
    .a     (a),
    .ir    (ir),
    .flags (flags)
  );

  initial ph0 = 1'b0;
  always #5 ph0 = ~ph0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  function automatic ctl_t nop();
    ctl_t c;
    c = '0;
    return c;
  endfunction

  task automatic model_reset();
    m_ac = 0; m_ai = 0; m_bi = 0; m_add = 0; m_dl = 0; m_ir = 0; m_oe = 0;
    m_n = 0; m_v = 0; m_z = 0; m_c = 0;
    m_a = 'hFFFC;
    for (int i = 0; i < int'(NIDX); i++) m_idx[i] = 0;
  endtask

  // One clock of architectural behaviour, using values from before the edge
  task automatic model_step(input ctl_t c, input int din, input logic r);
    int sbv, cin, res, co, ov, sum, ssum, lo, hi;
    if (!(r || c.wr)) return;
    case (c.sb_sel)
      SB_AC:   sbv = m_ac;
      SB_ADD:  sbv = m_add;
      SB_DL:   sbv = m_dl;
      SB_IDX:  sbv = (int'(c.idx) < int'(NIDX)) ? m_idx[c.idx] : 0;
      default: sbv = 0;
    endcase
    cin = c.cin_sel ? m_c : int'(c.cin_val);
    co = m_c; ov = 0; res = 0;
    case (c.alu_op)
      ALU_ADD: begin
        sum  = m_ai + m_bi + cin;
        res  = sum % 256;
        co   = (sum >= 256) ? 1 : 0;
        ssum = sgn(m_ai) + sgn(m_bi) + cin;
        ov   = (ssum > 127 || ssum < -128) ? 1 : 0;
      end
      ALU_AND: res = m_ai & m_bi;
      ALU_OR:  res = m_ai | m_bi;
      ALU_EOR: res = m_ai ^ m_bi;
      ALU_SR: begin
        res = cin * 128 + m_ai / 2;
        co  = m_ai % 2;
      end
      default: res = 0;
    endcase
    if (c.ld_flags_db) begin
      m_n = (m_dl >> 3) & 1; m_v = (m_dl >> 2) & 1; m_z = (m_dl >> 1) & 1; m_c = m_dl & 1;
    end else if (c.ld_add && c.upd_flags) begin
      m_n = (res >= 128) ? 1 : 0;
      m_z = (res == 0) ? 1 : 0;
      if (c.alu_op == ALU_ADD || c.alu_op == ALU_SR) m_c = co;
      if (c.alu_op == ALU_ADD) m_v = ov;
    end
    if (c.ld_abl || c.ld_abh) begin
      lo = c.ld_abl ? (c.adl_sel ? m_dl : m_add) : m_a % 256;
      hi = c.ld_abh ? (c.adh_sel ? m_dl : sbv) : m_a / 256;
      m_a = hi * 256 + lo;
    end else if (c.ab_inc) begin
      m_a = (m_a + 1) % 65536;
    end
    case (c.bi_sel)
      BI_DL:   m_bi = m_dl;
      BI_DL_N: m_bi = 255 - m_dl;
      BI_ADL:  m_bi = m_a_lo_prev(lo, c);
      default: ;
    endcase
    if (c.ld_ac) m_ac = sbv;
    if (c.ld_ai) m_ai = sbv;
    if (c.ld_idx && int'(c.idx) < int'(NIDX)) m_idx[c.idx] = sbv;
    if (c.ld_add) m_add = res;
    if (c.ld_ir) m_ir = din;
    m_dl = din;
    m_oe = int'(c.wr);
  endtask

  // BI_ADL samples the address low byte from before the edge
  int a_before;
  function automatic int m_a_lo_prev(input int unused_lo, input ctl_t unused_c);
    return a_before % 256;
  endfunction

  task automatic cycle(input ctl_t c, input int din, input logic r);
    ctl  = c;
    d_in = 8'(din);
    rdy  = r;
    @(posedge ph0);
    a_before = m_a;
    model_step(c, din, r);
    #1;
    check("d_out", 32'(d_out), 32'(m_ac));
    check("d_oe",  32'(d_oe),  32'(m_oe));
    check("a",     32'(a),     32'(m_a));
    check("ir",    32'(ir),    32'(m_ir));
    check("flags", 32'(flags), 32'(m_n * 8 + m_v * 4 + m_z * 2 + m_c));
  endtask

  initial begin
    ctl_t c;
    reset = 1'b1; rdy = 1'b1; ctl = '0; d_in = '0;
    model_reset();
    #12;
    check("rst_a", 32'(a), 32'h0000FFFC);
    check("rst_ac", 32'(d_out), 32'h0);
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_oe", 32'(d_oe), 32'h0);
    check("rst_ir", 32'(ir), 32'h0);
    @(negedge ph0);
    reset = 1'b0;

    // ADC with signed overflow: 50 + 50 = A0
    cycle(nop(), 'h50, 1'b1);
    c = nop(); c.sb_sel = SB_DL; c.ld_ac = 1'b1; cycle(c, 'h50, 1'b1);
    c = nop(); c.sb_sel = SB_AC; c.ld_ai = 1'b1; c.bi_sel = BI_DL; cycle(c, 'h50, 1'b1);
    c = nop(); c.alu_op = ALU_ADD; c.ld_add = 1'b1; c.upd_flags = 1'b1; cycle(c, 'h50, 1'b1);
    check("adc_flags", 32'(flags), 32'hC);
    c = nop(); c.sb_sel = SB_ADD; c.ld_ac = 1'b1; cycle(c, 'h50, 1'b1);
    check("adc_add", 32'(d_out), 32'hA0);

    // Subtract via ~DL with carry in
    cycle(nop(), 'h10, 1'b1);
    c = nop(); c.sb_sel = SB_DL; c.ld_ai = 1'b1; cycle(c, 'h01, 1'b1);
    c = nop(); c.bi_sel = BI_DL_N; cycle(c, 'h01, 1'b1);
    c = nop(); c.alu_op = ALU_ADD; c.cin_val = 1'b1; c.ld_add = 1'b1; c.upd_flags = 1'b1;
    cycle(c, 'h01, 1'b1);
    check("sbc1_flags", 32'(flags), 32'h1);
    c = nop(); c.sb_sel = SB_ADD; c.ld_ac = 1'b1; cycle(c, 'h01, 1'b1);
    check("sbc1_add", 32'(d_out), 32'h0F);
    c = nop(); c.sb_sel = SB_ZERO; c.ld_ai = 1'b1; cycle(c, 'h01, 1'b1);
    c = nop(); c.alu_op = ALU_ADD; c.cin_val = 1'b1; c.ld_add = 1'b1; c.upd_flags = 1'b1;
    cycle(c, 'h01, 1'b1);
    check("sbc2_flags", 32'(flags), 32'h8);
    c = nop(); c.sb_sel = SB_ADD; c.ld_ac = 1'b1; cycle(c, 'h01, 1'b1);
    check("sbc2_add", 32'(d_out), 32'hFF);

    // Address wrap and load-over-increment priority
    cycle(nop(), 'hFF, 1'b1);
    c = nop(); c.ld_abl = 1'b1; c.adl_sel = 1'b1; c.ld_abh = 1'b1; c.adh_sel = 1'b1;
    cycle(c, 'hFF, 1'b1);
    check("a_ffff", 32'(a), 32'hFFFF);
    c = nop(); c.ab_inc = 1'b1; cycle(c, 'h12, 1'b1);
    check("a_wrap", 32'(a), 32'h0000);
    c = nop(); c.ld_abh = 1'b1; c.adh_sel = 1'b1; cycle(c, 'hFF, 1'b1);
    c = nop(); c.ld_abl = 1'b1; c.adl_sel = 1'b1; cycle(c, 'h34, 1'b1);
    check("a_12ff", 32'(a), 32'h12FF);
    c = nop(); c.ld_abl = 1'b1; c.adl_sel = 1'b1; c.ab_inc = 1'b1; cycle(c, 'h00, 1'b1);
    check("a_inc_ld", 32'(a), 32'h1234);

    // RDY stall on reads, write completes without RDY
    c = nop(); c.sb_sel = SB_DL; c.ld_ac = 1'b1; c.ab_inc = 1'b1; c.ld_ir = 1'b1;
    cycle(c, 'h11, 1'b0);
    cycle(c, 'h22, 1'b0);
    cycle(c, 'h33, 1'b0);
    check("stall_a", 32'(a), 32'h1234);
    check("stall_ac", 32'(d_out), 32'hFF);
    check("stall_ir", 32'(ir), 32'h0);
    cycle(nop(), 'h5C, 1'b1);
    c = nop(); c.sb_sel = SB_DL; c.ld_ac = 1'b1; cycle(c, 'h00, 1'b1);
    check("rdy_dl", 32'(d_out), 32'h5C);
    c = nop(); c.wr = 1'b1; c.ab_inc = 1'b1; cycle(c, 'h00, 1'b0);
    check("wr_oe", 32'(d_oe), 32'h1);
    check("wr_a", 32'(a), 32'h1235);
    cycle(nop(), 'h00, 1'b0);
    check("oe_hold", 32'(d_oe), 32'h1);
    cycle(nop(), 'h00, 1'b1);
    check("oe_drop", 32'(d_oe), 32'h0);

    // Index registers, including an out-of-range index
    cycle(nop(), 'h77, 1'b1);
    c = nop(); c.sb_sel = SB_DL; c.ld_idx = 1'b1; c.idx = 3'd3; cycle(c, 'h77, 1'b1);
    c = nop(); c.sb_sel = SB_IDX; c.idx = 3'd3; c.ld_ac = 1'b1; cycle(c, 'h77, 1'b1);
    check("idx3", 32'(d_out), 32'h77);
    c = nop(); c.sb_sel = SB_DL; c.ld_idx = 1'b1; c.idx = 3'd5; cycle(c, 'h77, 1'b1);
    c = nop(); c.sb_sel = SB_IDX; c.idx = 3'd5; c.ld_ac = 1'b1; cycle(c, 'h77, 1'b1);
    check("idx5", 32'(d_out), 32'h00);

    // Asynchronous reset in the middle of a cycle
    cycle(nop(), 'h12, 1'b1);
    c = nop(); c.ld_abh = 1'b1; c.adh_sel = 1'b1; cycle(c, 'h34, 1'b1);
    c = nop(); c.ld_abl = 1'b1; c.adl_sel = 1'b1; cycle(c, 'h5A, 1'b1);
    c = nop(); c.sb_sel = SB_DL; c.ld_ac = 1'b1; cycle(c, 'h00, 1'b1);
    check("pre_rst_ac", 32'(d_out), 32'h5A);
    check("pre_rst_a", 32'(a), 32'h1234);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("arst_a", 32'(a), 32'hFFFC);
    check("arst_ac", 32'(d_out), 32'h0);
    check("arst_flags", 32'(flags), 32'h0);
    @(negedge ph0);
    reset = 1'b0;

    // Randomized control words
    for (int k = 0; k < 3000; k++) begin
      c = '0;
      c.sb_sel      = sb_sel_t'($urandom_range(0, 4));
      c.idx         = 3'($urandom_range(0, 7));
      c.ld_ac       = 1'($urandom);
      c.ld_idx      = 1'($urandom);
      c.ld_ai       = 1'($urandom);
      c.bi_sel      = bi_sel_t'($urandom_range(0, 3));
      c.alu_op      = alu_op_t'($urandom_range(0, 4));
      c.cin_sel     = 1'($urandom);
      c.cin_val     = 1'($urandom);
      c.ld_add      = 1'($urandom);
      c.upd_flags   = 1'($urandom);
      c.ld_flags_db = ($urandom_range(0, 7) == 0);
      c.ld_abl      = ($urandom_range(0, 3) == 0);
      c.adl_sel     = 1'($urandom);
      c.ld_abh      = ($urandom_range(0, 3) == 0);
      c.adh_sel     = 1'($urandom);
      c.ab_inc      = 1'($urandom);
      c.ld_ir       = 1'($urandom);
      c.wr          = ($urandom_range(0, 3) == 0);
      if (c.wr) c.ld_ac = 1'b0;
      cycle(c, int'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
